// File: rtl/ccu_multi.sv
// ccu_multi: multi-channel pedestrian crossing controller with per-channel phase timers and round-robin walk grants.
// Optional flash mode (all channels blinking orange) is compiled in with CCU_FLASH_EN.
module ccu_multi #(
    parameter int CHANNELS      = 2,
    parameter int CNT_W         = 16,
    parameter int GREEN_TICKS   = 20,
    parameter int ORANGE_TICKS  = 5,
    parameter int RED_MIN_TICKS = 10
`ifdef CCU_FLASH_EN
    ,
    parameter int FLASH_TICKS   = 4
`endif
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         tick,
    input  logic [CHANNELS-1:0]                          request,
`ifdef CCU_FLASH_EN
    input  logic                                         flash,
`endif
    output logic [CHANNELS-1:0]                          green_walk,
    output logic [CHANNELS-1:0]                          orange_walk,
    output logic [CHANNELS-1:0]                          red_hand,
    output logic [CHANNELS-1:0]                          tr,
    output logic                                         walk_valid,
    output logic [(CHANNELS > 1 ? $clog2(CHANNELS) : 1)-1:0] walk_ch
);
    localparam int CH_W = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
    localparam logic [CNT_W-1:0] G_LD = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] O_LD = CNT_W'(ORANGE_TICKS - 1);
    localparam logic [CNT_W-1:0] R_LD = CNT_W'(RED_MIN_TICKS - 1);

    typedef enum logic [1:0] {
        RED_HAND,
        GREEN_WALK,
        ORANGE_WALK
`ifdef CCU_FLASH_EN
        ,
        FLASH
`endif
    } state_t;

    state_t              st   [CHANNELS];
    state_t              st_n [CHANNELS];
    logic [CNT_W-1:0]    cnt  [CHANNELS];
    logic [CHANNELS-1:0] pend, red_done, cand, fin, chg, g_n, o_w, o_n, r_n;
    logic [CH_W-1:0]     last, gch, win, w_lo, w_hi;
    logic                gnt_v, grant, any_lo, any_hi;
`ifdef CCU_FLASH_EN
    localparam logic [CNT_W-1:0] F_LD = CNT_W'(FLASH_TICKS - 1);
    logic                in_fl, lit, lit_n;
    logic [CNT_W-1:0]    bcnt;
`endif

    always_comb begin
        any_lo = 1'b0;
        any_hi = 1'b0;
        w_lo = '0;
        w_hi = '0;
        // Lowest eligible index overall, and lowest above the last grant: the latter wins when present.
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            cand[i] = pend[i] && red_done[i] && st[i] == RED_HAND;
            if (cand[i]) begin
                any_lo = 1'b1;
                w_lo = CH_W'(i);
            end
            if (cand[i] && i > int'(last)) begin
                any_hi = 1'b1;
                w_hi = CH_W'(i);
            end
        end
        win = any_hi ? w_hi : w_lo;
`ifdef CCU_FLASH_EN
        grant = any_lo && !walk_valid && !gnt_v && !flash && !in_fl;
        lit_n = !in_fl ? 1'b1 : (tick && bcnt == '0) ? !lit : lit;
`else
        grant = any_lo && !walk_valid && !gnt_v;
`endif
        for (int i = 0; i < CHANNELS; i++) begin
            fin[i] = tick && cnt[i] == '0;
            case (st[i])
                GREEN_WALK:  st_n[i] = fin[i] ? ORANGE_WALK : GREEN_WALK;
                ORANGE_WALK: st_n[i] = fin[i] ? RED_HAND : ORANGE_WALK;
                default:     st_n[i] = gnt_v && gch == CH_W'(i) ? GREEN_WALK : RED_HAND;
            endcase
`ifdef CCU_FLASH_EN
            if (flash) st_n[i] = FLASH;
`endif
            chg[i] = st_n[i] != st[i];
            g_n[i] = st_n[i] == GREEN_WALK;
            o_w[i] = st_n[i] == ORANGE_WALK;
            r_n[i] = st_n[i] == RED_HAND;
`ifdef CCU_FLASH_EN
            o_n[i] = o_w[i] || (st_n[i] == FLASH && lit_n);
`else
            o_n[i] = o_w[i];
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                st[i]  <= RED_HAND;
                cnt[i] <= '0;
            end
            pend        <= '0;
            red_done    <= '1;
            green_walk  <= '0;
            orange_walk <= '0;
            red_hand    <= '1;
            tr          <= '0;
            walk_valid  <= 1'b0;
            walk_ch     <= '0;
            last        <= CH_W'(CHANNELS - 1);
            gch         <= '0;
            gnt_v       <= 1'b0;
`ifdef CCU_FLASH_EN
            in_fl       <= 1'b0;
            lit         <= 1'b0;
            bcnt        <= '0;
`endif
        end else begin
            gnt_v       <= grant;
            green_walk  <= g_n;
            orange_walk <= o_n;
            red_hand    <= r_n;
            tr          <= chg;
            walk_valid  <= |(g_n | o_w);
            if (grant) begin
                gch  <= win;
                last <= win;
            end
            if (|(g_n & chg)) walk_ch <= gch;
`ifdef CCU_FLASH_EN
            in_fl <= flash;
            lit   <= lit_n;
            bcnt  <= (!in_fl || (tick && bcnt == '0)) ? F_LD : tick ? bcnt - 1'b1 : bcnt;
`endif
            for (int i = 0; i < CHANNELS; i++) begin
                st[i] <= st_n[i];
`ifdef CCU_FLASH_EN
                pend[i] <= !flash && !(grant && win == CH_W'(i)) && (pend[i] || (request[i] && st[i] == RED_HAND));
`else
                pend[i] <= !(grant && win == CH_W'(i)) && (pend[i] || (request[i] && st[i] == RED_HAND));
`endif
                // Loading on entry means the entry-edge tick never counts toward the new phase.
                if (chg[i])
                    cnt[i] <= st_n[i] == GREEN_WALK ? G_LD : st_n[i] == ORANGE_WALK ? O_LD : R_LD;
                else if (tick && cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
                if (chg[i] && st_n[i] == RED_HAND)
                    red_done[i] <= 1'b0;
                else if (st[i] == RED_HAND && fin[i])
                    red_done[i] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ccu_multi.sv
// tb_ccu_multi: directed and randomized checks of ccu_multi against a tick-counting behavioural model.
module tb_ccu_multi;
    localparam int N = 2, G = 3, O = 2, RM = 4;
    localparam logic [1:0] EG [8] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    localparam logic [1:0] EO [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};
    localparam logic [1:0] ET [8] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b01};

    logic clk = 1'b0, reset = 1'b0, tick = 1'b0;
    logic [N-1:0] request = '0;
`ifdef CCU_FLASH_EN
    logic flash = 1'b0;
`endif
    logic [N-1:0] green_walk, orange_walk, red_hand, tr;
    logic walk_valid;
    logic [0:0] walk_ch;
    int checks = 0, failures = 0;

    // Model: phase 0=red 1=green 2=orange, rem = ticks still owed in the phase.
    int ph [N], rem [N];
    bit pend [N], rdone [N];
    bit m_gp;
    int m_gch, m_last, m_wch;
    logic [N-1:0] m_tr;

    ccu_multi #(
        .CHANNELS(N), .CNT_W(8), .GREEN_TICKS(G), .ORANGE_TICKS(O), .RED_MIN_TICKS(RM)
`ifdef CCU_FLASH_EN
        , .FLASH_TICKS(2)
`endif
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .request(request),
`ifdef CCU_FLASH_EN
        .flash(flash),
`endif
        .green_walk(green_walk), .orange_walk(orange_walk), .red_hand(red_hand), .tr(tr),
        .walk_valid(walk_valid), .walk_ch(walk_ch)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; rem[i] = 0; pend[i] = 0; rdone[i] = 1;
        end
        m_gp = 0; m_gch = 0; m_last = N - 1; m_wch = 0; m_tr = '0;
    endtask

    task automatic m_step(input logic [N-1:0] r, input logic t);
        int win, nph;
        bit busy;
        busy = m_gp;
        for (int i = 0; i < N; i++) busy |= ph[i] != 0;
        win = -1;
        if (!busy)
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (win < 0 && pend[c] && rdone[c] && ph[c] == 0) win = c;
            end
        for (int i = 0; i < N; i++) begin
            nph = ph[i];
            pend[i] = (win == i) ? 1'b0 : (pend[i] || (r[i] && ph[i] == 0));
            if (ph[i] != 0) begin
                if (t) rem[i]--;
                if (rem[i] == 0) nph = ph[i] == 1 ? 2 : 0;
            end else if (m_gp && m_gch == i) begin
                nph = 1;
            end else if (!rdone[i] && t) begin
                rem[i]--;
                if (rem[i] == 0) rdone[i] = 1;
            end
            m_tr[i] = nph != ph[i];
            if (nph != ph[i]) begin
                rem[i] = nph == 1 ? G : nph == 2 ? O : RM;
                if (nph == 0) rdone[i] = 0;
                if (nph == 1) m_wch = i;
            end
            ph[i] = nph;
        end
        m_gp = win >= 0;
        if (win >= 0) begin
            m_gch = win;
            m_last = win;
        end
    endtask

    task automatic check_all(input string tag);
        logic [N-1:0] g, o, rd;
        for (int i = 0; i < N; i++) begin
            g[i] = ph[i] == 1; o[i] = ph[i] == 2; rd[i] = ph[i] == 0;
        end
        chk({tag, ".green"}, 32'(green_walk), 32'(g));
        chk({tag, ".orange"}, 32'(orange_walk), 32'(o));
        chk({tag, ".red"}, 32'(red_hand), 32'(rd));
        chk({tag, ".tr"}, 32'(tr), 32'(m_tr));
        chk({tag, ".walk_valid"}, 32'(walk_valid), 32'(|(g | o)));
        chk({tag, ".walk_ch"}, 32'(walk_ch), 32'(m_wch));
        chk({tag, ".one_walker"}, 32'($countones(green_walk | orange_walk) <= 1), 32'd1);
    endtask

    task automatic step(input logic [N-1:0] r, input logic t, input string tag);
        request = r;
        tick = t;
        @(posedge clk);
        m_step(r, t);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step('0, 1'b1, "idle");
    endtask

    initial begin
        logic [N-1:0] rq;
        rq = '0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b1;
        // Pulse on ch0 with a tick every cycle: pend, grant, 3 green, 2 orange, red.
        for (int s = 0; s < 8; s++) begin
            step(s == 0 ? 2'b01 : 2'b00, 1'b1, "lat");
            chk("lat.green_c", 32'(green_walk), 32'(EG[s]));
            chk("lat.orange_c", 32'(orange_walk), 32'(EO[s]));
            chk("lat.tr_c", 32'(tr), 32'(ET[s]));
        end
        for (int s = 0; s < 40; s++) step(2'b11, 1'b1, "rr");
        idle(15);
        // Request on ch1 repeated while it walks must not cause a second grant.
        for (int s = 0; s < 25; s++) step((s == 0 || s == 3) ? 2'b10 : 2'b00, 1'b1, "ign");
        idle(10);
        // Sparse ticks with ticks on the grant and entry edges.
        for (int s = 0; s < 30; s++) step(s == 0 ? 2'b01 : 2'b00, (s == 1 || s == 2) ? 1'b1 : 1'(s % 2), "sparse");
        for (int c = 0; c < 300; c++) begin
            if (c % 6 == 0) rq = N'($urandom_range(0, 3));
            step(rq, 1'($urandom_range(0, 2) != 0), "rand");
        end
        idle(15);
        for (int s = 0; s < 3; s++) step(s == 0 ? 2'b10 : 2'b00, 1'b0, "pre_rst");
        chk("pre_rst.green_c", 32'(green_walk), 32'h2);
        #2 reset = 1'b0;
        #1;
        m_reset();
        chk("arst.red", 32'(red_hand), 32'h3);
        chk("arst.green", 32'(green_walk), 32'h0);
        chk("arst.tr", 32'(tr), 32'h0);
        chk("arst.walk_valid", 32'(walk_valid), 32'h0);
        chk("arst.walk_ch", 32'(walk_ch), 32'h0);
        @(posedge clk);
        #1;
        check_all("arst_hold");
        reset = 1'b1;
        for (int s = 0; s < 12; s++) step(s == 0 ? 2'b01 : 2'b00, 1'b1, "post_rst");
`ifdef CCU_FLASH_EN
        idle(10);
        for (int s = 0; s < 6; s++) step(s == 0 ? 2'b01 : 2'b00, 1'b1, "to_orange");
        chk("to_orange.orange_c", 32'(orange_walk), 32'h1);
        flash = 1'b1;
        for (int s = 0; s < 5; s++) begin
            request = 2'b11;
            tick = 1'b1;
            @(posedge clk);
            #1;
            chk("flash.orange", 32'(orange_walk), (s == 2 || s == 3) ? 32'h0 : 32'h3);
            chk("flash.green", 32'(green_walk), 32'h0);
            chk("flash.red", 32'(red_hand), 32'h0);
            chk("flash.tr", 32'(tr), s == 0 ? 32'h3 : 32'h0);
            chk("flash.walk_valid", 32'(walk_valid), 32'h0);
        end
        flash = 1'b0;
        request = '0;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            ph[i] = 0; rem[i] = RM; rdone[i] = 0; pend[i] = 0;
        end
        m_gp = 0;
        m_tr = '1;
        check_all("flash_exit");
        for (int s = 0; s < 14; s++) step(2'b01, 1'b1, "post_flash");
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
